// File: rtl/rv2t_instruction_fetch_queue.sv
// rv2t_instruction_fetch_queue
// Fetch stage feeding instruction decode. Issues one word read at a time to
// instruction memory, keeps up to two fetched {PC, IR} pairs in a small FIFO,
// and hands one pair to decode per fetch_next. A redirect flushes buffered
// entries and discards the data of a read that is still on the bus.
module rv2t_instruction_fetch_queue #(
  parameter int XLEN        = 32,
  parameter int PC_BITWIDTH = 24
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sync_reset,
  input  logic                   fetch_start,
  input  logic [PC_BITWIDTH-1:0] start_addr,
  input  logic                   fetch_next,
  input  logic                   jump_active,
  input  logic [PC_BITWIDTH-1:0] jump_addr,
  output logic                   mem_read_req,
  output logic [PC_BITWIDTH-1:0] mem_read_addr,
  input  logic                   mem_read_ack,
  input  logic [XLEN-1:0]        mem_read_data,
  output logic                   enable_out,
  output logic [XLEN-1:0]        IR_out,
  output logic [PC_BITWIDTH-1:0] PC_out,
  output logic                   exception_instruction_addr_misaligned
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  // Control state
  state_t                 r_state;
  logic [PC_BITWIDTH-1:0] r_fetch_pc;   // address of the current / next read
  logic [PC_BITWIDTH-1:0] r_addr;       // address held on the bus while a read is outstanding
  logic                   r_req;        // a read is outstanding (req held until ack)
  logic                   r_drop;       // outstanding read belongs to a flushed stream
  logic [1:0]             r_count;      // FIFO occupancy, 0..2
  logic                   r_head;       // FIFO read slot
  logic                   r_pending;    // decode asked while the FIFO was empty
  logic                   r_enable;
  logic [XLEN-1:0]        r_ir_out;
  logic [PC_BITWIDTH-1:0] r_pc_out;
  logic                   r_exc;

  // FIFO storage (data only, never needs a reset value)
  logic [PC_BITWIDTH-1:0] r_q_pc [2];
  logic [XLEN-1:0]        r_q_ir [2];

  // Per-cycle decisions
  logic                   w_run;
  logic                   w_ack;
  logic                   w_jump;
  logic                   w_jump_mis;
  logic                   w_start;
  logic                   w_start_mis;
  logic                   w_flush;
  logic                   w_run_nxt;
  logic                   w_push;
  logic                   w_want_pop;
  logic                   w_pop;
  logic                   w_still_out;
  logic [1:0]             w_count_nxt;
  logic                   w_issue;
  logic                   w_tail;
  logic [PC_BITWIDTH-1:0] w_pc_nxt;

  assign w_run       = (r_state == S_RUN);
  // An ack only counts while a read is actually outstanding; a reset abandons it.
  assign w_ack       = mem_read_ack && r_req;
  assign w_jump      = w_run && jump_active;
  assign w_jump_mis  = w_jump && (jump_addr[1:0] != 2'b00);
  assign w_start     = !w_run && fetch_start;
  assign w_start_mis = w_start && (start_addr[1:0] != 2'b00);
  assign w_flush     = w_jump || w_start;
  assign w_run_nxt   = (w_run && !w_jump_mis) || (w_start && !w_start_mis);
  // Redirect beats an arriving ack, and data of a flushed stream is discarded.
  assign w_push      = w_ack && !r_drop && !w_flush;
  assign w_want_pop  = w_run && (fetch_next || r_pending);
  assign w_pop       = w_want_pop && (r_count != 2'd0) && !w_flush;
  assign w_still_out = r_req && !w_ack;
  assign w_tail      = r_head ^ r_count[0];
  // Issue only with the bus idle and room left for the returning word.
  assign w_issue     = w_run_nxt && !w_still_out && (w_count_nxt < 2'd2);

  assign mem_read_req                          = r_req;
  assign mem_read_addr                         = r_addr;
  assign enable_out                            = r_enable;
  assign IR_out                                = r_ir_out;
  assign PC_out                                = r_pc_out;
  assign exception_instruction_addr_misaligned = r_exc;

  // Next FIFO occupancy and next fetch PC for this cycle's events
  always_comb begin
    w_count_nxt = r_count;
    if (w_flush) begin
      w_count_nxt = 2'd0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + 2'd1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 2'd1;
    end

    w_pc_nxt = r_fetch_pc;
    if (w_jump && !w_jump_mis) begin
      w_pc_nxt = jump_addr;
    end else if (w_start && !w_start_mis) begin
      w_pc_nxt = start_addr;
    end else if (w_push) begin
      w_pc_nxt = r_fetch_pc + PC_BITWIDTH'(4);
    end
  end

  // State machine, bus handshake, FIFO pointers and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= '0;
      r_addr     <= '0;
      r_req      <= 1'b0;
      r_drop     <= 1'b0;
      r_count    <= 2'd0;
      r_head     <= 1'b0;
      r_pending  <= 1'b0;
      r_enable   <= 1'b0;
      r_ir_out   <= '0;
      r_pc_out   <= '0;
      r_exc      <= 1'b0;
    end else if (sync_reset) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= '0;
      r_addr     <= '0;
      r_req      <= 1'b0;
      r_drop     <= 1'b0;
      r_count    <= 2'd0;
      r_head     <= 1'b0;
      r_pending  <= 1'b0;
      r_enable   <= 1'b0;
      r_ir_out   <= '0;
      r_pc_out   <= '0;
      r_exc      <= 1'b0;
    end else begin
      if (w_jump_mis || w_start_mis) begin
        r_state <= S_HALT;
      end else if (w_start) begin
        r_state <= S_RUN;
      end

      r_fetch_pc <= w_pc_nxt;
      r_count    <= w_count_nxt;
      r_exc      <= w_jump_mis || w_start_mis;

      if (w_issue) begin
        r_req  <= 1'b1;
        r_addr <= w_pc_nxt;
      end else if (w_ack) begin
        r_req  <= 1'b0;
      end

      // A flushed read still finishes on the bus; remember to ignore its data.
      if (w_flush && w_still_out) begin
        r_drop <= 1'b1;
      end else if (w_ack) begin
        r_drop <= 1'b0;
      end

      if (w_flush) begin
        r_head <= 1'b0;
      end else if (w_pop) begin
        r_head <= ~r_head;
      end

      r_pending <= w_want_pop && !w_pop && !w_flush;

      r_enable <= w_pop;
      if (w_pop) begin
        r_ir_out <= r_q_ir[r_head];
        r_pc_out <= r_q_pc[r_head];
      end
    end
  end

  // FIFO write port: fetched word lands at the tail slot
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[w_tail] <= r_addr;
      r_q_ir[w_tail] <= mem_read_data;
    end
  end

endmodule

// File: tb/tb_rv2t_instruction_fetch_queue.sv
// Directed bench for rv2t_instruction_fetch_queue. Memory returns {8'h5A, addr}
// as the instruction word for any address, either acking in the request cycle
// (auto_ack) or under explicit control (man_ack).
module tb_rv2t_instruction_fetch_queue;
  localparam int XLEN = 32;
  localparam int PCW  = 24;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            sync_reset;
  logic            fetch_start;
  logic [PCW-1:0]  start_addr;
  logic            fetch_next;
  logic            jump_active;
  logic [PCW-1:0]  jump_addr;
  logic            mem_read_req;
  logic [PCW-1:0]  mem_read_addr;
  logic            mem_read_ack;
  logic [XLEN-1:0] mem_read_data;
  logic            enable_out;
  logic [XLEN-1:0] IR_out;
  logic [PCW-1:0]  PC_out;
  logic            exc;

  logic auto_ack;
  logic man_ack;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] ir_of(input logic [PCW-1:0] a);
    return {8'h5A, a};
  endfunction

  assign mem_read_ack  = auto_ack ? mem_read_req : man_ack;
  assign mem_read_data = ir_of(mem_read_addr);

  rv2t_instruction_fetch_queue #(.XLEN(XLEN), .PC_BITWIDTH(PCW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sync_reset(sync_reset),
    .fetch_start(fetch_start),
    .start_addr(start_addr),
    .fetch_next(fetch_next),
    .jump_active(jump_active),
    .jump_addr(jump_addr),
    .mem_read_req(mem_read_req),
    .mem_read_addr(mem_read_addr),
    .mem_read_ack(mem_read_ack),
    .mem_read_data(mem_read_data),
    .enable_out(enable_out),
    .IR_out(IR_out),
    .PC_out(PC_out),
    .exception_instruction_addr_misaligned(exc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    fetch_start = 1'b0; fetch_next = 1'b0; jump_active = 1'b0;
    auto_ack = 1'b0; man_ack = 1'b0; sync_reset = 1'b1;
    step();
    sync_reset = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sync_reset = 1'b0; fetch_start = 1'b0; start_addr = '0;
    fetch_next = 1'b0; jump_active = 1'b0; jump_addr = '0; auto_ack = 1'b0; man_ack = 1'b0;
    #22;
    checks++;
    if (mem_read_req !== 1'b0 || mem_read_addr !== 24'h0 || enable_out !== 1'b0 ||
        IR_out !== 32'h0 || PC_out !== 24'h0 || exc !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs req=%b addr=%h en=%b ir=%h pc=%h exc=%b required all 0",
               mem_read_req, mem_read_addr, enable_out, IR_out, PC_out, exc);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    // sync_reset wins over a simultaneous fetch_start
    sync_reset = 1'b1; fetch_start = 1'b1; start_addr = 24'h100;
    step();
    sync_reset = 1'b0; fetch_start = 1'b0;
    checks++;
    if (mem_read_req !== 1'b0) begin
      errors++;
      $display("FAIL sync_reset_priority req=%b required 0", mem_read_req);
    end
    step();
    checks++;
    if (mem_read_req !== 1'b0) begin
      errors++;
      $display("FAIL sync_reset_idle req=%b required 0", mem_read_req);
    end
  endtask

  task automatic test_stream();
    clr();
    start_addr = 24'h100; fetch_start = 1'b1; fetch_next = 1'b1; auto_ack = 1'b1;
    step(); // c1
    fetch_start = 1'b0;
    checks++;
    if (mem_read_req !== 1'b1 || mem_read_addr !== 24'h100) begin
      errors++;
      $display("FAIL stream_first_req req=%b addr=%h required 1/000100", mem_read_req, mem_read_addr);
    end
    step(); // c2
    checks++;
    if (enable_out !== 1'b0 || mem_read_req !== 1'b1 || mem_read_addr !== 24'h104) begin
      errors++;
      $display("FAIL stream_c2 en=%b req=%b addr=%h required 0/1/000104", enable_out, mem_read_req, mem_read_addr);
    end
    for (int k = 0; k < 3; k++) begin
      step(); // c3..c5
      checks++;
      if (enable_out !== 1'b1 || PC_out !== 24'h100 + 24'(4*k) || IR_out !== ir_of(24'h100 + 24'(4*k))) begin
        errors++;
        $display("FAIL stream_out%0d en=%b pc=%h ir=%h required 1/%h/%h", k, enable_out, PC_out, IR_out,
                 24'h100 + 24'(4*k), ir_of(24'h100 + 24'(4*k)));
      end
    end
    fetch_next = 1'b0; auto_ack = 1'b0;
  endtask

  task automatic test_backpressure();
    clr();
    start_addr = 24'h0; fetch_start = 1'b1; auto_ack = 1'b1;
    step(); // c1
    fetch_start = 1'b0;
    checks++;
    if (mem_read_req !== 1'b1 || mem_read_addr !== 24'h0) begin
      errors++;
      $display("FAIL bp_req0 req=%b addr=%h required 1/000000", mem_read_req, mem_read_addr);
    end
    step(); // c2
    checks++;
    if (mem_read_req !== 1'b1 || mem_read_addr !== 24'h4) begin
      errors++;
      $display("FAIL bp_req4 req=%b addr=%h required 1/000004", mem_read_req, mem_read_addr);
    end
    for (int k = 0; k < 2; k++) begin
      step(); // c3, c4
      checks++;
      if (mem_read_req !== 1'b0) begin
        errors++;
        $display("FAIL bp_full_idle%0d req=%b required 0", k, mem_read_req);
      end
    end
    fetch_next = 1'b1;
    step(); // c5
    fetch_next = 1'b0;
    checks++;
    if (mem_read_req !== 1'b1 || mem_read_addr !== 24'h8 || enable_out !== 1'b1 ||
        PC_out !== 24'h0 || IR_out !== ir_of(24'h0)) begin
      errors++;
      $display("FAIL bp_pop_refill req=%b addr=%h en=%b pc=%h ir=%h required 1/000008/1/000000/%h",
               mem_read_req, mem_read_addr, enable_out, PC_out, IR_out, ir_of(24'h0));
    end
    auto_ack = 1'b0;
  endtask

  task automatic test_redirect_outstanding();
    clr();
    start_addr = 24'h10; fetch_start = 1'b1;
    step(); // c1
    fetch_start = 1'b0;
    checks++;
    if (mem_read_req !== 1'b1 || mem_read_addr !== 24'h10) begin
      errors++;
      $display("FAIL rd_req10 req=%b addr=%h required 1/000010", mem_read_req, mem_read_addr);
    end
    jump_active = 1'b1; jump_addr = 24'h200;
    step(); // c2
    jump_active = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (mem_read_req !== 1'b1 || mem_read_addr !== 24'h10) begin
        errors++;
        $display("FAIL rd_hold%0d req=%b addr=%h required 1/000010", k, mem_read_req, mem_read_addr);
      end
      step(); // c3, c4
    end
    man_ack = 1'b1;
    step(); // c5
    man_ack = 1'b0;
    checks++;
    if (mem_read_req !== 1'b1 || mem_read_addr !== 24'h200) begin
      errors++;
      $display("FAIL rd_new_req req=%b addr=%h required 1/000200", mem_read_req, mem_read_addr);
    end
    auto_ack = 1'b1; fetch_next = 1'b1;
    step(); // c6
    checks++;
    if (enable_out !== 1'b0) begin
      errors++;
      $display("FAIL rd_no_stale en=%b pc=%h required 0", enable_out, PC_out);
    end
    step(); // c7
    fetch_next = 1'b0; auto_ack = 1'b0;
    checks++;
    if (enable_out !== 1'b1 || PC_out !== 24'h200 || IR_out !== ir_of(24'h200)) begin
      errors++;
      $display("FAIL rd_first_out en=%b pc=%h ir=%h required 1/000200/%h", enable_out, PC_out, IR_out, ir_of(24'h200));
    end
  endtask

  task automatic test_jump_vs_next();
    clr();
    start_addr = 24'h40; fetch_start = 1'b1; auto_ack = 1'b1;
    step(); // c1
    fetch_start = 1'b0;
    step(); // c2
    step(); // c3: queue holds 0x40, 0x44
    checks++;
    if (mem_read_req !== 1'b0) begin
      errors++;
      $display("FAIL jn_full req=%b required 0", mem_read_req);
    end
    jump_active = 1'b1; jump_addr = 24'h300; fetch_next = 1'b1;
    step(); // c4
    jump_active = 1'b0; fetch_next = 1'b0;
    checks++;
    if (enable_out !== 1'b0 || mem_read_req !== 1'b1 || mem_read_addr !== 24'h300) begin
      errors++;
      $display("FAIL jn_redirect en=%b req=%b addr=%h required 0/1/000300", enable_out, mem_read_req, mem_read_addr);
    end
    step(); // c5
    checks++;
    if (enable_out !== 1'b0 || mem_read_addr !== 24'h304) begin
      errors++;
      $display("FAIL jn_pending_dropped en=%b addr=%h required 0/000304", enable_out, mem_read_addr);
    end
    fetch_next = 1'b1;
    step(); // c6
    fetch_next = 1'b0; auto_ack = 1'b0;
    checks++;
    if (enable_out !== 1'b1 || PC_out !== 24'h300) begin
      errors++;
      $display("FAIL jn_head_after_flush en=%b pc=%h required 1/000300", enable_out, PC_out);
    end
  endtask

  task automatic test_misaligned();
    clr();
    start_addr = 24'h80; fetch_start = 1'b1; auto_ack = 1'b1;
    step(); // c1
    fetch_start = 1'b0;
    jump_active = 1'b1; jump_addr = 24'h202;
    step(); // c2
    jump_active = 1'b0;
    checks++;
    if (exc !== 1'b1 || mem_read_req !== 1'b0) begin
      errors++;
      $display("FAIL mis_pulse exc=%b req=%b required 1/0", exc, mem_read_req);
    end
    fetch_next = 1'b1;
    step(); // c3
    fetch_next = 1'b0;
    checks++;
    if (exc !== 1'b0 || mem_read_req !== 1'b0 || enable_out !== 1'b0) begin
      errors++;
      $display("FAIL mis_halt exc=%b req=%b en=%b required 0/0/0", exc, mem_read_req, enable_out);
    end
    step(); // c4
    checks++;
    if (mem_read_req !== 1'b0) begin
      errors++;
      $display("FAIL mis_halt_noreq req=%b required 0", mem_read_req);
    end
    start_addr = 24'h0; fetch_start = 1'b1;
    step(); // c5
    fetch_start = 1'b0;
    checks++;
    if (mem_read_req !== 1'b1 || mem_read_addr !== 24'h0 || exc !== 1'b0) begin
      errors++;
      $display("FAIL mis_resume req=%b addr=%h exc=%b required 1/000000/0", mem_read_req, mem_read_addr, exc);
    end
    clr();
    start_addr = 24'h101; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    checks++;
    if (exc !== 1'b1 || mem_read_req !== 1'b0) begin
      errors++;
      $display("FAIL mis_start exc=%b req=%b required 1/0", exc, mem_read_req);
    end
    step();
    checks++;
    if (exc !== 1'b0 || mem_read_req !== 1'b0) begin
      errors++;
      $display("FAIL mis_start_after exc=%b req=%b required 0/0", exc, mem_read_req);
    end
  endtask

  task automatic test_async_reset();
    clr();
    start_addr = 24'h20; fetch_start = 1'b1; fetch_next = 1'b1; auto_ack = 1'b1;
    step(); // c1
    fetch_start = 1'b0;
    step(); // c2
    step(); // c3
    auto_ack = 1'b0; fetch_next = 1'b0;
    checks++;
    if (enable_out !== 1'b1 || PC_out !== 24'h20) begin
      errors++;
      $display("FAIL ar_pre_out en=%b pc=%h required 1/000020", enable_out, PC_out);
    end
    step(); // c4: read 0x28 outstanding
    checks++;
    if (mem_read_req !== 1'b1 || mem_read_addr !== 24'h28) begin
      errors++;
      $display("FAIL ar_outstanding req=%b addr=%h required 1/000028", mem_read_req, mem_read_addr);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem_read_req !== 1'b0 || mem_read_addr !== 24'h0 || enable_out !== 1'b0 ||
        IR_out !== 32'h0 || PC_out !== 24'h0 || exc !== 1'b0) begin
      errors++;
      $display("FAIL ar_outputs req=%b addr=%h en=%b ir=%h pc=%h exc=%b required all 0",
               mem_read_req, mem_read_addr, enable_out, IR_out, PC_out, exc);
    end
    @(negedge clk);
    reset_n = 1'b1;
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (mem_read_req !== 1'b0 || enable_out !== 1'b0) begin
        errors++;
        $display("FAIL ar_ack_ignored%0d req=%b en=%b required 0/0", k, mem_read_req, enable_out);
      end
      step();
    end
  endtask

  task automatic test_wrap();
    clr();
    start_addr = 24'hFFFFFC; fetch_start = 1'b1; fetch_next = 1'b1; auto_ack = 1'b1;
    step(); // c1
    fetch_start = 1'b0;
    checks++;
    if (mem_read_addr !== 24'hFFFFFC) begin
      errors++;
      $display("FAIL wrap_first addr=%h required fffffc", mem_read_addr);
    end
    step(); // c2
    checks++;
    if (mem_read_req !== 1'b1 || mem_read_addr !== 24'h000000) begin
      errors++;
      $display("FAIL wrap_next req=%b addr=%h required 1/000000", mem_read_req, mem_read_addr);
    end
    step(); // c3
    step(); // c4
    fetch_next = 1'b0; auto_ack = 1'b0;
    checks++;
    if (enable_out !== 1'b1 || PC_out !== 24'h000000 || IR_out !== ir_of(24'h0)) begin
      errors++;
      $display("FAIL wrap_out en=%b pc=%h ir=%h required 1/000000/%h", enable_out, PC_out, IR_out, ir_of(24'h0));
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_outstanding();
    test_jump_vs_next();
    test_misaligned();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
